// File: rtl/zbus_seq.sv
// Z80 bus access sequencer: deglitches the bus strobes, decodes I/O and ROM-window accesses, and sequences
// SL811/W5300 chip selects or register-port writes. Define ZBUS_WAIT_EN to add the zwait_n output.
module zbus_seq #(
  parameter logic [7:0] BASE_ADDR = 8'hAB,
  parameter int         FILT_LEN  = 2,
  parameter int         N_PORTS   = 4,
  parameter int         CS_SETUP  = 1,
  parameter int         CS_HOLD   = 1
) (
  input  logic                           fclk,
  input  logic                           rst,
  input  logic [15:0]                    za,
  input  logic [7:0]                     zd_in,
  output logic [7:0]                     zd_out,
  output logic                           zd_oe,
  input  logic                           ziorq_n,
  input  logic                           zmreq_n,
  input  logic                           zrd_n,
  input  logic                           zwr_n,
  input  logic                           zcsrom_n,
  output logic                           ziorqge,
  output logic                           zblkrom,
  output logic                           ports_wrstb,
  output logic [$clog2(N_PORTS)-1:0]     ports_addr,
  output logic [7:0]                     ports_wrdata,
  input  logic [8*N_PORTS-1:0]           ports_rddata,
  input  logic [1:0]                     rommap_win,
  input  logic                           rommap_ena,
  input  logic                           w5300_ports,
  output logic                           sl811_cs_n,
  output logic                           sl811_a0,
  output logic                           w5300_cs_n,
`ifdef ZBUS_WAIT_EN
  output logic                           zwait_n,
`endif
  input  logic [7:0]                     bd_in,
  output logic [7:0]                     bd_out,
  output logic                           bd_oe
);

  localparam int AW = $clog2(N_PORTS);
  localparam int NS = 5;
  localparam int IORQ = 0, MREQ = 1, RD = 2, WR = 3, CSROM = 4;

  typedef enum logic [1:0] {IDLE, SETUP, ACTIVE, HOLD} state_t;
  typedef enum logic [1:0] {TGT_SL811, TGT_W5300, TGT_PORT} tgt_t;

  state_t                      state_q, state_d;
  tgt_t                        tgt_q, tgt_new;
  logic [3:0]                  cnt_q, cnt_d;
  logic [NS-1:0]               strobe_n, filt_q, filt;
  logic [NS-1:0][FILT_LEN-1:0] sh_q;
  logic mem_q, wr_q, a15_q, block_q, block_d;
  logic io_acc, mem_acc, any_strobe, cur_strobe, accept;
  logic setup_done, hold_done, in_act_d, enter_active;
  logic [7:0] rd_sel;
  logic unused_za;

  assign strobe_n  = {zcsrom_n, zwr_n, zrd_n, zmreq_n, ziorq_n};
  assign unused_za = ^za;

  // Filtered strobe (active-high "asserted") changes only on a unanimous shift register.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    filt = filt_q;
    for (int i = 0; i < NS; i++) begin
      if (sh_q[i] == '0)  filt[i] = 1'b1;
      else if (&sh_q[i])  filt[i] = 1'b0;
    end
  end

  assign ziorqge    = (za[7:0] == BASE_ADDR);
  assign zblkrom    = rommap_ena && (za[15:14] == rommap_win);
  assign io_acc     = filt[IORQ] && (filt[RD] || filt[WR]) && ziorqge;
  assign mem_acc    = filt[MREQ] && zblkrom && (filt[WR] || (filt[RD] && filt[CSROM]));
  assign any_strobe = (filt[IORQ] || filt[MREQ]) && (filt[RD] || filt[WR]);
  assign cur_strobe = (mem_q ? filt[MREQ] : filt[IORQ]) && (wr_q ? filt[WR] : filt[RD]);
  assign setup_done = ({1'b0, cnt_q} + 5'd1) >= 5'(CS_SETUP);
  assign hold_done  = ({1'b0, cnt_q} + 5'd1) >= 5'(CS_HOLD);
  assign rd_sel     = (tgt_q == TGT_PORT) ? ports_rddata[{ports_addr, 3'b000} +: 8] : bd_in;
  assign sl811_a0   = ~a15_q;

  always_comb begin
    if (!io_acc)                     tgt_new = TGT_W5300;
    else if (!za[15] && w5300_ports) tgt_new = TGT_W5300;
    else if (!za[15] || za[8 +: AW] == '0) tgt_new = TGT_SL811;
    else                             tgt_new = TGT_PORT;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: if ((io_acc || mem_acc) && !block_q) begin
        accept  = 1'b1;
        state_d = SETUP;
        cnt_d   = '0;
      end
      SETUP: begin
        if (!cur_strobe)     state_d = IDLE;
        else if (setup_done) state_d = ACTIVE;
        else                 cnt_d   = cnt_q + 4'd1;
      end
      ACTIVE: if (!cur_strobe) begin
        state_d = HOLD;
        cnt_d   = '0;
      end
      HOLD: begin
        if (hold_done) state_d = IDLE;
        else           cnt_d   = cnt_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // One access per strobe: a strobe still held when IDLE is reached must be released first.
  always_comb begin
    block_d = block_q;
    if (accept)                                block_d = 1'b1;
    else if (state_q == IDLE && !any_strobe)   block_d = 1'b0;
  end

  assign in_act_d     = (state_d == ACTIVE) || (state_d == HOLD);
  assign enter_active = (state_q == SETUP) && (state_d == ACTIVE);

  always_ff @(posedge fclk) begin
    if (rst) begin
      sh_q         <= '1;
      filt_q       <= '0;
      state_q      <= IDLE;
      cnt_q        <= '0;
      mem_q        <= 1'b0;
      wr_q         <= 1'b0;
      a15_q        <= 1'b0;
      tgt_q        <= TGT_SL811;
      block_q      <= 1'b0;
      ports_addr   <= '0;
      ports_wrdata <= '0;
      sl811_cs_n   <= 1'b1;
      w5300_cs_n   <= 1'b1;
      ports_wrstb  <= 1'b0;
      zd_oe        <= 1'b0;
      bd_oe        <= 1'b0;
      zd_out       <= '0;
      bd_out       <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      for (int i = 0; i < NS; i++) sh_q[i] <= {sh_q[i][FILT_LEN-2:0], strobe_n[i]};
      filt_q  <= filt;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      block_q <= block_d;
      if (accept) begin
        mem_q        <= !io_acc;
        wr_q         <= filt[WR];
        a15_q        <= za[15];
        tgt_q        <= tgt_new;
        ports_addr   <= za[8 +: AW];
        ports_wrdata <= zd_in;
      end
      sl811_cs_n  <= !(in_act_d && tgt_q == TGT_SL811);
      w5300_cs_n  <= !(in_act_d && tgt_q == TGT_W5300);
      ports_wrstb <= enter_active && wr_q && tgt_q == TGT_PORT;
      zd_oe       <= in_act_d && !wr_q;
      bd_oe       <= in_act_d && wr_q && tgt_q != TGT_PORT;
      if (enter_active && wr_q && tgt_q != TGT_PORT) bd_out <= ports_wrdata;
      if (state_d == ACTIVE && !wr_q)                zd_out <= rd_sel;
    end
  end

`ifdef ZBUS_WAIT_EN
  // WAIT covers all of SETUP plus the first ACTIVE cycle.
  always_ff @(posedge fclk) begin
    if (rst) zwait_n <= 1'b1;
    else     zwait_n <= !((state_d == SETUP) || enter_active);
  end
`endif

endmodule
